// File: rtl/mpadder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mpadder_pkg
//  Description : Shared constants, command opcodes and sequencer state
//                encoding for the mpadder command sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mpadder_pkg;

    localparam int NCHUNK       = 5;
    localparam int SEL_W        = 4;
    localparam int ITER_W       = 3;
    localparam int MAX_SUB_ITER = 4;

    // Select value that keeps every adder result/carry register from loading
    localparam logic [3:0] CHUNK_PARK = 4'b1000;

    typedef enum logic [1:0] {
        OP_ACC     = 2'd0,
        OP_SHIFT   = 2'd1,
        OP_RESOLVE = 2'd2,
        OP_REDUCE  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACC  = 3'd1,
        ST_SHF  = 3'd2,
        ST_RES  = 3'd3,
        ST_RED  = 3'd4,
        ST_RSP  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mpadder_sequencer_chunk_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : mpseq_chunk_cnt
//  Description : Registered chunk select for the adder: park, start at 0,
//                step with wrap, plus a last-chunk flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mpseq_chunk_cnt
    import mpadder_pkg::*;
#(
    parameter int               NCHUNK = mpadder_pkg::NCHUNK,
    parameter int               SEL_W  = mpadder_pkg::SEL_W,
    parameter logic [SEL_W-1:0] PARK   = SEL_W'(CHUNK_PARK)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             park,
    input  logic             start,
    input  logic             step,
    output logic [SEL_W-1:0] chunk_sel,
    output logic             last
);

    logic [SEL_W-1:0] r_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel <= PARK;
        end else if (start) begin
            r_sel <= '0;
        end else if (step) begin
            r_sel <= (r_sel == SEL_W'(NCHUNK - 1)) ? '0 : r_sel + 1'b1;
        end else if (park) begin
            r_sel <= PARK;
        end
    end

    assign chunk_sel = r_sel;
    assign last      = (r_sel == SEL_W'(NCHUNK - 1));

endmodule
`default_nettype wire

// File: rtl/mpadder_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mpadder_sequencer
//  Description : Turns ACC/SHIFT/RESOLVE/REDUCE commands into the registered
//                control pattern for one mpadder instance.
//                Optional feature macro: MPSEQ_TIMEOUT_EN (reduce abort).
//  Revision    : 1.0 - initial release
// ============================================================================
module mpadder_sequencer
    import mpadder_pkg::*;
#(
    parameter int NCHUNK       = mpadder_pkg::NCHUNK,
    parameter int SEL_W        = mpadder_pkg::SEL_W,
    parameter int MAX_SUB_ITER = mpadder_pkg::MAX_SUB_ITER,
    parameter int ITER_W       = mpadder_pkg::ITER_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [ITER_W-1:0] rsp_iters,
    output logic              rsp_lsb,
    output logic              add_enable_c,
    output logic              add_shift,
    output logic              add_subtract,
    output logic [SEL_W-1:0]  add_chunk_sel,
    input  logic              add_sub_finished,
    input  logic              add_c_zero
);

`ifdef MPSEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    state_t              r_state, w_state_n;
    logic [ITER_W-1:0]   r_pass, w_pass_n;
    logic [ITER_W-1:0]   r_iters, w_iters_n;
    logic                r_ready, w_ready_n;
    logic                r_valid, w_valid_n;
    logic                r_err, w_err_n;
    logic                r_lsb, w_lsb_n;
    logic                r_en, w_en_n;
    logic                r_shf, w_shf_n;
    logic                r_sub, w_sub_n;
    logic                w_park, w_start, w_step, w_last;

    mpseq_chunk_cnt #(
        .NCHUNK (NCHUNK),
        .SEL_W  (SEL_W),
        .PARK   (SEL_W'(CHUNK_PARK))
    ) u_chunk_cnt (
        .clk       (clk),
        .reset     (reset),
        .park      (w_park),
        .start     (w_start),
        .step      (w_step),
        .chunk_sel (add_chunk_sel),
        .last      (w_last)
    );

    // Next-state logic computes the values every control output takes next cycle
    always_comb begin
        w_state_n = r_state;
        w_pass_n  = r_pass;
        w_iters_n = '0;
        w_ready_n = 1'b0;
        w_valid_n = 1'b0;
        w_err_n   = 1'b0;
        w_lsb_n   = 1'b0;
        w_en_n    = 1'b0;
        w_shf_n   = 1'b0;
        w_sub_n   = 1'b0;
        w_park    = 1'b0;
        w_start   = 1'b0;
        w_step    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_ready_n = 1'b1;
                w_park    = 1'b1;
                if (cmd_valid && r_ready) begin
                    w_ready_n = 1'b0;
                    w_pass_n  = '0;
                    unique case (op_t'(cmd_op))
                        OP_ACC: begin
                            w_state_n = ST_ACC;
                            w_en_n    = 1'b1;
                        end
                        OP_SHIFT: begin
                            w_state_n = ST_SHF;
                            w_shf_n   = 1'b1;
                        end
                        OP_RESOLVE: begin
                            w_state_n = ST_RES;
                            w_start   = 1'b1;
                            w_park    = 1'b0;
                        end
                        OP_REDUCE: begin
                            w_state_n = ST_RED;
                            w_sub_n   = 1'b1;
                            w_start   = 1'b1;
                            w_park    = 1'b0;
                        end
                    endcase
                end
            end
            ST_ACC, ST_SHF: begin
                w_state_n = ST_RSP;
                w_valid_n = 1'b1;
                w_lsb_n   = add_c_zero;
                w_park    = 1'b1;
            end
            ST_RES: begin
                if (w_last) begin
                    w_state_n = ST_RSP;
                    w_valid_n = 1'b1;
                    w_lsb_n   = add_c_zero;
                    w_park    = 1'b1;
                end else begin
                    w_step = 1'b1;
                end
            end
            ST_RED: begin
                if (w_last && add_sub_finished) begin
                    w_state_n = ST_RSP;
                    w_valid_n = 1'b1;
                    w_iters_n = r_pass;
                    w_lsb_n   = add_c_zero;
                    w_park    = 1'b1;
                end else if (w_last && TIMEOUT_EN &&
                             r_pass == ITER_W'(MAX_SUB_ITER - 1)) begin
                    w_state_n = ST_RSP;
                    w_valid_n = 1'b1;
                    w_err_n   = 1'b1;
                    w_iters_n = ITER_W'(MAX_SUB_ITER);
                    w_lsb_n   = add_c_zero;
                    w_park    = 1'b1;
                end else begin
                    w_sub_n = 1'b1;
                    w_step  = 1'b1;
                    if (w_last && r_pass != '1) begin
                        w_pass_n = r_pass + 1'b1;
                    end
                end
            end
            ST_RSP: begin
                w_state_n = ST_IDLE;
                w_ready_n = 1'b1;
                w_park    = 1'b1;
            end
            default: begin
                w_state_n = ST_IDLE;
                w_ready_n = 1'b1;
                w_park    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pass  <= '0;
            r_iters <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_lsb   <= 1'b0;
            r_en    <= 1'b0;
            r_shf   <= 1'b0;
            r_sub   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_pass  <= w_pass_n;
            r_iters <= w_iters_n;
            r_ready <= w_ready_n;
            r_valid <= w_valid_n;
            r_err   <= w_err_n;
            r_lsb   <= w_lsb_n;
            r_en    <= w_en_n;
            r_shf   <= w_shf_n;
            r_sub   <= w_sub_n;
        end
    end

    assign cmd_ready    = r_ready;
    assign rsp_valid    = r_valid;
    assign rsp_err      = r_err;
    assign rsp_iters    = r_iters;
    assign rsp_lsb      = r_lsb;
    assign add_enable_c = r_en;
    assign add_shift    = r_shf;
    assign add_subtract = r_sub;

endmodule
`default_nettype wire

// File: tb/tb_mpadder_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mpadder_sequencer
//  Description : Directed self-checking bench for mpadder_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mpadder_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       rsp_valid;
    logic       rsp_err;
    logic [2:0] rsp_iters;
    logic       rsp_lsb;
    logic       add_enable_c;
    logic       add_shift;
    logic       add_subtract;
    logic [3:0] add_chunk_sel;
    logic       add_sub_finished;
    logic       add_c_zero;

    int n_chk  = 0;
    int n_fail = 0;

    mpadder_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .rsp_valid        (rsp_valid),
        .rsp_err          (rsp_err),
        .rsp_iters        (rsp_iters),
        .rsp_lsb          (rsp_lsb),
        .add_enable_c     (add_enable_c),
        .add_shift        (add_shift),
        .add_subtract     (add_subtract),
        .add_chunk_sel    (add_chunk_sel),
        .add_sub_finished (add_sub_finished),
        .add_c_zero       (add_c_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Idle image {ready, rsp_valid, enable, shift, subtract, chunk_sel} = 1_0000_1000
    task automatic chk_idle(input string tag);
        chk(tag, {23'd0, cmd_ready, rsp_valid, add_enable_c, add_shift, add_subtract,
                  add_chunk_sel}, 32'h108);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset            = 1'b1;
        cmd_valid        = 1'b0;
        cmd_op           = 2'd0;
        add_sub_finished = 1'b0;
        add_c_zero       = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        chk_idle("reset_outputs");
        chk("reset_err",   {31'd0, rsp_err}, 32'd0);
        chk("reset_iters", {29'd0, rsp_iters}, 32'd0);
        chk("reset_lsb",   {31'd0, rsp_lsb}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk_idle("idle_quiet");
        end

        // ACC
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        step();
        cmd_valid = 1'b0;
        chk("acc_en_t1",    {31'd0, add_enable_c}, 32'd1);
        chk("acc_shift_t1", {31'd0, add_shift}, 32'd0);
        chk("acc_ready_t1", {31'd0, cmd_ready}, 32'd0);
        chk("acc_valid_t1", {31'd0, rsp_valid}, 32'd0);
        step();
        chk("acc_en_t2",    {31'd0, add_enable_c}, 32'd0);
        chk("acc_valid_t2", {31'd0, rsp_valid}, 32'd1);
        chk("acc_iters",    {29'd0, rsp_iters}, 32'd0);
        chk("acc_err",      {31'd0, rsp_err}, 32'd0);
        step();
        chk_idle("acc_t3_idle");

        // RESOLVE with cZero high on the last chunk
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        for (int i = 0; i < 5; i++) begin
            step();
            cmd_valid = 1'b0;
            chk("res_chunk", {28'd0, add_chunk_sel}, i);
            chk("res_sub",   {31'd0, add_subtract}, 32'd0);
            chk("res_valid", {31'd0, rsp_valid}, 32'd0);
            if (i == 4) add_c_zero = 1'b1;
        end
        step();
        add_c_zero = 1'b0;
        chk("res_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("res_rsp_lsb",   {31'd0, rsp_lsb}, 32'd1);
        chk("res_rsp_park",  {28'd0, add_chunk_sel}, 32'd8);
        chk("res_rsp_iters", {29'd0, rsp_iters}, 32'd0);
        step();
        chk_idle("res_t7_idle");

        // REDUCE finishing on the third pass
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        for (int i = 0; i < 15; i++) begin
            step();
            cmd_valid = 1'b0;
            chk("red_chunk", {28'd0, add_chunk_sel}, i % 5);
            chk("red_sub",   {31'd0, add_subtract}, 32'd1);
            chk("red_valid", {31'd0, rsp_valid}, 32'd0);
            if (i == 14) add_sub_finished = 1'b1;
        end
        step();
        add_sub_finished = 1'b0;
        chk("red_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("red_rsp_iters", {29'd0, rsp_iters}, 32'd2);
        chk("red_rsp_err",   {31'd0, rsp_err}, 32'd0);
        chk("red_rsp_sub",   {31'd0, add_subtract}, 32'd0);
        chk("red_rsp_park",  {28'd0, add_chunk_sel}, 32'd8);
        chk("red_rsp_lsb",   {31'd0, rsp_lsb}, 32'd0);
        step();
        chk_idle("red_idle");

        // REDUCE that never finishes
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
`ifdef MPSEQ_TIMEOUT_EN
        for (int i = 0; i < 20; i++) begin
            step();
            cmd_valid = 1'b0;
            chk("to_chunk", {28'd0, add_chunk_sel}, i % 5);
            chk("to_valid", {31'd0, rsp_valid}, 32'd0);
        end
        step();
        chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("to_rsp_err",   {31'd0, rsp_err}, 32'd1);
        chk("to_rsp_iters", {29'd0, rsp_iters}, 32'd4);
        step();
        chk_idle("to_idle");
`else
        for (int i = 0; i < 100; i++) begin
            step();
            cmd_valid = 1'b0;
            chk("loop_valid", {31'd0, rsp_valid}, 32'd0);
        end
        chk("loop_chunk_c100", {28'd0, add_chunk_sel}, 32'd4);
        chk("loop_sub_c100",   {31'd0, add_subtract}, 32'd1);
        chk("loop_err_c100",   {31'd0, rsp_err}, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle("loop_reset_idle");
`endif

        // Reset during the second RESOLVE chunk
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        step();
        cmd_valid = 1'b0;
        chk("rst_chunk0", {28'd0, add_chunk_sel}, 32'd0);
        step();
        chk("rst_chunk1", {28'd0, add_chunk_sel}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle("rst_abort");
        chk("rst_abort_iters", {29'd0, rsp_iters}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk_idle("rst_no_rsp");
        end

        // SHIFT after the abort
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        step();
        cmd_valid = 1'b0;
        chk("shf_shift_t1", {31'd0, add_shift}, 32'd1);
        chk("shf_en_t1",    {31'd0, add_enable_c}, 32'd0);
        chk("shf_park_t1",  {28'd0, add_chunk_sel}, 32'd8);
        step();
        chk("shf_shift_t2", {31'd0, add_shift}, 32'd0);
        chk("shf_valid_t2", {31'd0, rsp_valid}, 32'd1);
        chk("shf_iters",    {29'd0, rsp_iters}, 32'd0);
        step();
        chk_idle("shf_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
